// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the nRisc fetch unit: default widths, reset vector and FSM encoding.
// The state values are fixed so that waveforms and other blocks can decode them directly.
package pc_fetch_unit_pkg;

  localparam int unsigned NRISC_PC_WIDTH    = 8;
  localparam int unsigned NRISC_INSTR_WIDTH = 8;
  localparam logic [7:0]  NRISC_RESET_VECTOR = 8'h00;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StExec   = 2'd2,
    StHalted = 2'd3
  } fetch_state_e;

  // An executing instruction retires only when neither halted nor stalled.
  function automatic logic exec_retires(input logic stall, input logic halt);
    return !halt && !stall;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: asynchronous reset to a fixed vector, synchronous load enable.
module pc_reg #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the 8-bit nRisc core.
// Handshake outputs are registered alongside the state so they track it exactly.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = NRISC_PC_WIDTH,
  parameter int unsigned         INSTR_WIDTH  = NRISC_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(NRISC_RESET_VECTOR)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    pc_next,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [PC_WIDTH-1:0]    pc1,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic                   halted
);

  fetch_state_e state_q;
  logic         pc_load;

  // The PC moves only when the executing instruction retires.
  assign pc_load = (state_q == StExec) && exec_retires(stall, halt);

  pc_reg #(
    .WIDTH       (PC_WIDTH),
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc_reg (
    .clock (clock),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc_out)
  );

  assign pc1       = pc_out + PC_WIDTH'(1);
  assign imem_addr = pc_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q  <= StFetch;
          imem_req <= 1'b1;
        end
        StFetch: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state_q     <= StExec;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        StExec: begin
          // Halt takes priority over stall.
          if (halt) begin
            state_q     <= StHalted;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (!stall) begin
            state_q     <= StFetch;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q     <= StIdle;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random traffic,
// compared each cycle against a transaction-level model of the fetch/execute loop.
module tb_pc_fetch_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc_next = 8'h00;
  logic       stall = 1'b0;
  logic       halt = 1'b0;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] pc_out;
  logic [7:0] pc1;
  logic [7:0] instr;
  logic       instr_valid;
  logic       halted;

  int total = 0;
  int bad = 0;

  // Model: has the core left reset idle, is an instruction in hand, has it stopped.
  bit         m_started;
  bit         m_have;
  bit         m_stopped;
  logic [7:0] m_pc;
  logic [7:0] m_instr;

  pc_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .pc_next     (pc_next),
    .stall       (stall),
    .halt        (halt),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc_out      (pc_out),
    .pc1         (pc1),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0;
    m_have    = 0;
    m_stopped = 0;
    m_pc      = 8'h00;
    m_instr   = 8'h00;
  endtask

  task automatic model_step();
    if (m_stopped) begin
      // halted: nothing moves
    end else if (!m_started) begin
      m_started = 1;
    end else if (!m_have) begin
      if (imem_ack) begin
        m_instr = imem_rdata;
        m_have  = 1;
      end
    end else if (halt) begin
      m_stopped = 1;
    end else if (!stall) begin
      m_pc   = pc_next;
      m_have = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, {24'h0, pc_out}, {24'h0, m_pc});
    chk({tag, ".pc1"}, {24'h0, pc1}, {24'h0, m_pc + 8'h01});
    chk({tag, ".addr"}, {24'h0, imem_addr}, {24'h0, m_pc});
    chk({tag, ".instr"}, {24'h0, instr}, {24'h0, m_instr});
    chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, m_started && !m_have && !m_stopped});
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, m_have && !m_stopped});
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, m_stopped});
  endtask

  // Called at a falling edge: drive inputs, check outputs, clock once, return at falling edge.
  task automatic cyc(input string tag, input logic ack, input logic [7:0] rdata,
                     input logic [7:0] pnext, input logic stl, input logic hlt);
    imem_ack   = ack;
    imem_rdata = rdata;
    pc_next    = pnext;
    stall      = stl;
    halt       = hlt;
    check_all(tag);
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clock);

    // 1: reset values
    do_reset("t1");
    chk("t1.pc1_is_01", {24'h0, pc1}, 32'h01);

    // 2: fetch with two cycles of ack delay
    cyc("t2.idle", 0, 8'h00, 8'h00, 0, 0);
    cyc("t2.f0", 0, 8'h11, 8'h00, 0, 0);
    cyc("t2.f1", 0, 8'h22, 8'h00, 0, 0);
    chk("t2.req_third", {31'h0, imem_req}, 32'h1);
    cyc("t2.f2", 1, 8'hA5, 8'h00, 0, 0);
    chk("t2.instr_a5", {24'h0, instr}, 32'hA5);
    cyc("t2.exec", 0, 8'h00, 8'h01, 0, 0);
    chk("t2.valid_one_cycle", {31'h0, instr_valid}, 32'h0);
    chk("t2.pc_01", {24'h0, pc_out}, 32'h01);
    chk("t2.pc1_02", {24'h0, pc1}, 32'h02);

    // 3: branch from 10 to 0D
    cyc("t3.f", 1, 8'h3C, 8'h00, 0, 0);
    cyc("t3.e", 0, 8'h00, 8'h10, 0, 0);
    cyc("t3.f2", 1, 8'h4D, 8'h00, 0, 0);
    chk("t3.pc_10", {24'h0, pc_out}, 32'h10);
    cyc("t3.e2", 0, 8'h00, 8'h0D, 0, 0);
    chk("t3.addr_0d", {24'h0, imem_addr}, 32'h0D);
    chk("t3.pc1_0e", {24'h0, pc1}, 32'h0E);

    // 4: three stall cycles with stray acks
    cyc("t4.f", 1, 8'h5A, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t4.stall", 1, 8'hFF, 8'h77, 1, 0);
    chk("t4.valid_4th", {31'h0, instr_valid}, 32'h1);
    chk("t4.instr_kept", {24'h0, instr}, 32'h5A);
    chk("t4.pc_kept", {24'h0, pc_out}, 32'h0D);
    cyc("t4.go", 0, 8'h00, 8'h20, 0, 0);
    chk("t4.pc_20", {24'h0, pc_out}, 32'h20);

    // 5: wrap-around from FF
    cyc("t5.f", 1, 8'h01, 8'h00, 0, 0);
    cyc("t5.e", 0, 8'h00, 8'hFF, 0, 0);
    chk("t5.pc1_00", {24'h0, pc1}, 32'h00);
    cyc("t5.f2", 1, 8'h02, 8'h00, 0, 0);
    cyc("t5.e2", 0, 8'h00, 8'h00, 0, 0);
    chk("t5.pc_00", {24'h0, pc_out}, 32'h00);
    chk("t5.addr_00", {24'h0, imem_addr}, 32'h00);

    // 6: halt beats stall, then reset mid-fetch
    cyc("t6.f", 1, 8'h99, 8'h00, 0, 0);
    cyc("t6.e", 0, 8'h00, 8'h44, 1, 1);
    for (int i = 0; i < 3; i++) cyc("t6.halted", 1, 8'h12, 8'h55, 0, 0);
    chk("t6.halted_flag", {31'h0, halted}, 32'h1);
    do_reset("t6.rst");
    cyc("t6.idle", 0, 8'h00, 8'h00, 0, 0);
    cyc("t6.fetch", 0, 8'h00, 8'h00, 0, 0);
    imem_ack = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("t6.req_drop", {31'h0, imem_req}, 32'h0);
    chk("t6.valid_drop", {31'h0, instr_valid}, 32'h0);
    chk("t6.pc_reset", {24'h0, pc_out}, 32'h00);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    imem_ack = 1'b0;
    check_all("t6.restart");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if (m_stopped && ($urandom_range(0, 3) == 0)) begin
        do_reset("rnd.rst");
      end else begin
        cyc("rnd", ($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
